// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar slave-port arbiter: FSM encoding,
// slave-select address bit and timeout abort data.
package crossbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam int unsigned SLAVE_SEL_BIT = 31;
  localparam logic [31:0] ABORT_DATA    = 32'hDEADBEEF;

  // Extract master idx's 32-bit lane from a packed two-master bus.
  function automatic logic [31:0] lane32(input logic [63:0] bus, input logic idx);
    return idx ? bus[63:32] : bus[31:0];
  endfunction

endpackage

// File: rtl/crossbar_slave_arbiter_rr_arb2.sv
// Two-requester round-robin pick: on a tie the requester not granted last
// wins; a lone requester wins regardless of the pointer.
module rr_arb2 (
  input  logic [1:0] elig,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  always_comb begin
    valid = |elig;
    grant = 1'b0;
    if (&elig) grant = ~last_grant;
    else       grant = elig[1];
  end

endmodule

// File: rtl/crossbar_slave_arbiter.sv
// Slave-side port of a two-master crossbar: round-robin arbitration,
// IDLE/BUSY/RESP handshake, optional BUSY timeout abort (ARB_TIMEOUT_EN).
module crossbar_slave_arbiter
  import crossbar_pkg::*;
#(
  parameter logic        SLAVE_ID       = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  m_req,
  input  logic [1:0]  m_cmd,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_ack,
  output logic        s_req,
  output logic        s_cmd,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic        err
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t  state_q, state_d;
  logic [1:0]  elig;
  logic        pick_valid, pick;
  logic        grant_q;
  logic        cmd_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        timeout;

  assign elig[0] = m_req[0] & (m_addr[SLAVE_SEL_BIT]      == SLAVE_ID);
  assign elig[1] = m_req[1] & (m_addr[32 + SLAVE_SEL_BIT] == SLAVE_ID);

  rr_arb2 u_rr_arb2 (
    .elig       (elig),
    .last_grant (grant_q),
    .valid      (pick_valid),
    .grant      (pick)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] busy_cnt_q;
  logic             abort_q;

  assign timeout = (state_q == ST_BUSY) && !s_ack &&
                   (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      busy_cnt_q <= busy_cnt_q + CNT_W'(1);
      abort_q    <= timeout;
    end else begin
      busy_cnt_q <= '0;
    end
  end

  assign err = (state_q == ST_RESP) && abort_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_valid)       state_d = ST_BUSY;
      ST_BUSY: if (s_ack || timeout) state_d = ST_RESP;
      ST_RESP:                       state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // grant_q doubles as the round-robin pointer; resetting it to 1 lets
  // master 0 win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= 1'b1;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && pick_valid) begin
        grant_q <= pick;
        cmd_q   <= m_cmd[pick];
        addr_q  <= lane32(m_addr, pick);
        wdata_q <= lane32(m_wdata, pick);
      end
      if (state_q == ST_BUSY) begin
        if (s_ack)        rdata_q <= s_rdata;
        else if (timeout) rdata_q <= ABORT_DATA;
      end
    end
  end

  assign s_req   = (state_q == ST_BUSY);
  assign s_cmd   = cmd_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign m_rdata = rdata_q;
  assign m_ack   = (state_q != ST_RESP) ? 2'b00 : (grant_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_crossbar_slave_arbiter.sv
// Directed self-checking bench for crossbar_slave_arbiter (SLAVE_ID=0).
module tb_crossbar_slave_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_req;
  logic [1:0]  m_cmd;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [31:0] m_rdata;
  logic [1:0]  m_ack;
  logic        s_req;
  logic        s_cmd;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ack;
  logic        err;

  int unsigned checks = 0;
  int unsigned passes = 0;

  crossbar_slave_arbiter #(.SLAVE_ID(1'b0), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req   (m_req),
    .m_cmd   (m_cmd),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .s_req   (s_req),
    .s_cmd   (s_cmd),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_ack   (s_ack),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; m_req = 2'b00; m_cmd = 2'b00; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_ack = 1'b0;
    #1;
    checks++; if (m_ack !== 2'b00) $display("FAIL reset_m_ack: got %b expected 00", m_ack); else passes++;
    checks++; if (s_req !== 1'b0) $display("FAIL reset_s_req: got %b expected 0", s_req); else passes++;
    checks++; if (m_rdata !== 32'h0) $display("FAIL reset_m_rdata: got %h expected 0", m_rdata); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passes++;
    checks++; if ({s_cmd, s_addr, s_wdata} !== 65'h0) $display("FAIL reset_s_bus: got %h expected 0", {s_cmd, s_addr, s_wdata}); else passes++;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_tie;
    m_req = 2'b11; m_cmd = 2'b01;
    m_addr = {32'h0000_1234, 32'h0000_0abc}; m_wdata = {32'h2222_0001, 32'h1111_0000};
    step(1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0000_0abc) $display("FAIL tie_first_grant: got req=%b addr=%h expected 1/00000abc", s_req, s_addr); else passes++;
    checks++; if (s_cmd !== 1'b1 || s_wdata !== 32'h1111_0000) $display("FAIL tie_first_cmd: got cmd=%b wdata=%h expected 1/11110000", s_cmd, s_wdata); else passes++;
    s_ack = 1'b1; s_rdata = 32'h0000_aaaa;
    step(1);
    checks++; if (m_ack !== 2'b01) $display("FAIL tie_first_ack: got %b expected 01", m_ack); else passes++;
    s_ack = 1'b0;
    step(1);
    checks++; if (s_req !== 1'b0 || m_ack !== 2'b00) $display("FAIL tie_idle_gap: got req=%b ack=%b expected 0/00", s_req, m_ack); else passes++;
    step(1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0000_1234 || s_cmd !== 1'b0) $display("FAIL tie_second_grant: got req=%b addr=%h cmd=%b expected 1/00001234/0", s_req, s_addr, s_cmd); else passes++;
    s_ack = 1'b1; s_rdata = 32'h0000_bbbb;
    step(1);
    checks++; if (m_ack !== 2'b10 || m_rdata !== 32'h0000_bbbb) $display("FAIL tie_second_ack: got ack=%b rdata=%h expected 10/0000bbbb", m_ack, m_rdata); else passes++;
    m_req = 2'b01; s_ack = 1'b0;
    step(2);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0000_0abc) $display("FAIL b2b_grant: got req=%b addr=%h expected 1/00000abc", s_req, s_addr); else passes++;
    s_ack = 1'b1;
    step(1);
    checks++; if (m_ack !== 2'b01) $display("FAIL b2b_ack: got %b expected 01", m_ack); else passes++;
    m_req = 2'b00; s_ack = 1'b0;
    step(2);
  endtask

  task automatic test_single;
    m_req = 2'b01; m_cmd = 2'b00; m_addr = {32'h0, 32'h0000_add0}; m_wdata = '0;
    #1;
    checks++; if (s_req !== 1'b0) $display("FAIL single_idle_req: got %b expected 0", s_req); else passes++;
    step(1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0000_add0 || m_ack !== 2'b00) $display("FAIL single_busy: got req=%b addr=%h ack=%b expected 1/0000add0/00", s_req, s_addr, m_ack); else passes++;
    s_ack = 1'b1; s_rdata = 32'hfeed_00c0;
    step(1);
    checks++; if (m_ack !== 2'b01 || m_rdata !== 32'hfeed_00c0) $display("FAIL single_ack: got ack=%b rdata=%h expected 01/feed00c0", m_ack, m_rdata); else passes++;
    checks++; if (s_req !== 1'b0 || err !== 1'b0) $display("FAIL single_resp_flags: got req=%b err=%b expected 0/0", s_req, err); else passes++;
    m_req = 2'b00; s_ack = 1'b0;
    step(1);
    checks++; if (m_ack !== 2'b00) $display("FAIL single_ack_width: got %b expected 00", m_ack); else passes++;
    step(1);
  endtask

  task automatic test_misroute;
    m_req = 2'b01; m_addr = {32'h0, 32'h8000_0010};
    for (int unsigned i = 0; i < 4; i++) begin
      step(1);
      checks++; if (s_req !== 1'b0 || m_ack !== 2'b00) $display("FAIL misroute_cycle%0d: got req=%b ack=%b expected 0/00", i, s_req, m_ack); else passes++;
    end
    m_req = 2'b00;
    step(1);
  endtask

  task automatic test_stray_ack_withdraw;
    s_ack = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step(1);
      checks++; if (m_ack !== 2'b00 || s_req !== 1'b0) $display("FAIL stray_ack_cycle%0d: got ack=%b req=%b expected 00/0", i, m_ack, s_req); else passes++;
    end
    s_ack = 1'b0; m_req = 2'b10; m_cmd = 2'b10; m_addr = {32'h0000_0044, 32'h0};
    step(1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0000_0044 || s_cmd !== 1'b1) $display("FAIL withdraw_grant: got req=%b addr=%h cmd=%b expected 1/00000044/1", s_req, s_addr, s_cmd); else passes++;
    m_req = 2'b00; m_addr = '0;
    step(1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0000_0044 || m_ack !== 2'b00) $display("FAIL withdraw_hold: got req=%b addr=%h ack=%b expected 1/00000044/00", s_req, s_addr, m_ack); else passes++;
    s_ack = 1'b1; s_rdata = 32'h1111_2222;
    step(1);
    checks++; if (m_ack !== 2'b10 || m_rdata !== 32'h1111_2222) $display("FAIL withdraw_ack: got ack=%b rdata=%h expected 10/11112222", m_ack, m_rdata); else passes++;
    s_ack = 1'b0;
    step(1);
    checks++; if (m_ack !== 2'b00 || s_req !== 1'b0) $display("FAIL withdraw_done: got ack=%b req=%b expected 00/0", m_ack, s_req); else passes++;
  endtask

  task automatic test_slow_slave;
    m_req = 2'b01; m_cmd = 2'b00; m_addr = {32'h0, 32'h0000_0100};
`ifdef ARB_TIMEOUT_EN
    step(16);
    checks++; if (s_req !== 1'b1 || m_ack !== 2'b00) $display("FAIL timeout_last_busy: got req=%b ack=%b expected 1/00", s_req, m_ack); else passes++;
    step(1);
    checks++; if (m_ack !== 2'b01 || m_rdata !== 32'hDEADBEEF || err !== 1'b1) $display("FAIL timeout_abort: got ack=%b rdata=%h err=%b expected 01/deadbeef/1", m_ack, m_rdata, err); else passes++;
    m_req = 2'b00;
    step(1);
    checks++; if (m_ack !== 2'b00 || err !== 1'b0) $display("FAIL timeout_clear: got ack=%b err=%b expected 00/0", m_ack, err); else passes++;
`else
    step(40);
    checks++; if (s_req !== 1'b1 || m_ack !== 2'b00 || err !== 1'b0) $display("FAIL long_wait: got req=%b ack=%b err=%b expected 1/00/0", s_req, m_ack, err); else passes++;
    s_ack = 1'b1; s_rdata = 32'h0bad_cafe;
    step(1);
    checks++; if (m_ack !== 2'b01 || m_rdata !== 32'h0bad_cafe || err !== 1'b0) $display("FAIL long_wait_ack: got ack=%b rdata=%h err=%b expected 01/0badcafe/0", m_ack, m_rdata, err); else passes++;
    m_req = 2'b00; s_ack = 1'b0;
    step(1);
`endif
    step(1);
  endtask

  task automatic test_reset_mid;
    m_req = 2'b10; m_addr = {32'h0000_0200, 32'h0};
    step(1);
    checks++; if (s_req !== 1'b1) $display("FAIL rstmid_busy: got %b expected 1", s_req); else passes++;
    #2 reset = 1'b1; m_req = 2'b00;
    #1;
    checks++; if (s_req !== 1'b0 || m_ack !== 2'b00 || m_rdata !== 32'h0 || s_addr !== 32'h0) $display("FAIL rstmid_outputs: got req=%b ack=%b rdata=%h addr=%h expected 0/00/0/0", s_req, m_ack, m_rdata, s_addr); else passes++;
    step(1);
    reset = 1'b0; s_ack = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step(1);
      checks++; if (m_ack !== 2'b00 || s_req !== 1'b0) $display("FAIL rstmid_after_cycle%0d: got ack=%b req=%b expected 00/0", i, m_ack, s_req); else passes++;
    end
    s_ack = 1'b0;
  endtask

  initial begin
    test_reset;
    test_tie;
    test_single;
    test_misroute;
    test_stray_ack_withdraw;
    test_slow_slave;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
